// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef logic [31:0] word_addr_t;

  typedef struct packed {
    word_addr_t  pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP        = 32'hA800_0000;
  localparam word_addr_t  DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// fetch_if : instruction memory, decode handshake and redirect signals
// Revision : 1.0
// ============================================================================
interface fetch_if;
  import fetch_pkg::*;

  word_addr_t  imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  word_addr_t  if_pc;
  logic        if_ready;
  logic        redirect_valid;
  word_addr_t  redirect_target;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc,
    input  imem_instr, if_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc,
    output imem_instr, if_ready, redirect_valid, redirect_target
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous FIFO of {pc, instr} entries with flush
// Revision   : 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= bump(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= bump(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; an empty FIFO presents an all-zero head instead.
  assign count_o = count_q;
  assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, one-deep imem pipeline, buffered handoff to decode
// Revision   : 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter word_addr_t RESET_PC   = DEFAULT_RESET_PC,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  word_addr_t    pc_q;
  word_addr_t    pc_d;
  word_addr_t    inflight_pc_q;
  word_addr_t    inflight_pc_d;
  logic          inflight_q;
  logic          inflight_d;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic          w_pop;
  logic          w_issue;
  logic [CW:0]   w_occupancy;

  assign w_pop = bus.if_valid & bus.if_ready;

  // Credit: entries buffered plus the one in flight, less the one leaving now.
  assign w_occupancy = (CW+1)'(w_count) + (CW+1)'(inflight_q) - (CW+1)'(w_pop);
  assign w_issue     = !bus.redirect_valid && (w_occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_target;
    end else if (w_issue) begin
      pc_d          = pc_q + 32'd1;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign w_push_data.pc    = inflight_pc_q;
  assign w_push_data.instr = bus.imem_instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q & ~bus.redirect_valid),
    .push_data_i (w_push_data),
    .pop_i       (w_pop & ~bus.redirect_valid),
    .flush_i     (bus.redirect_valid),
    .count_o     (w_count),
    .head_o      (w_head)
  );

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (w_count != '0);
  assign bus.if_instr  = w_head.instr;
  assign bus.if_pc     = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector table, wrap sequence and random scoreboard
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] M0 = 32'h2200_0005;
  localparam logic [31:0] M1 = 32'h2440_0003;
  localparam logic [31:0] M2 = 32'hA800_0000;
  localparam logic [31:0] M3 = 32'hA000_FFFD;
  localparam logic [31:0] M4 = 32'hA800_0000;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[7:0])
      8'd0:    return M0;
      8'd1:    return M1;
      8'd2:    return M2;
      8'd3:    return M3;
      8'd4:    return M4;
      default: return {8'hC3, a[7:0], ~a[7:0], a[7:0]};
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       rv;
  word_addr_t tgt;

  always #5 clk = ~clk;

  fetch_if bus_a ();
  fetch_if bus_b ();

  assign bus_a.if_ready        = rdy;
  assign bus_a.redirect_valid  = rv;
  assign bus_a.redirect_target = tgt;
  assign bus_b.if_ready        = rdy;
  assign bus_b.redirect_valid  = rv;
  assign bus_b.redirect_target = tgt;

  always @(posedge clk) begin
    bus_a.imem_instr <= mem_word(bus_a.imem_addr);
    bus_b.imem_instr <= mem_word(bus_b.imem_addr);
  end

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFE), .FIFO_DEPTH(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic        r;
    logic        rdy;
    logic        rv;
    word_addr_t  tgt;
    logic        chk;
    logic        ev;
    word_addr_t  epc;
    logic [31:0] ei;
    word_addr_t  ea;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic rd, input logic v, input word_addr_t t,
                     input logic c, input logic ev, input word_addr_t epc,
                     input logic [31:0] ei, input word_addr_t ea);
    tv.push_back('{r, rd, v, t, c, ev, epc, ei, ea});
  endtask

  task automatic add_rst();
    add(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Rows for cycles 0..n-1 after reset with decode always ready.
  task automatic add_run(input int n);
    logic [31:0] hd [5];
    hd = '{M0, M1, M2, M3, M4};
    for (int k = 0; k < n; k++) begin
      if (k < 2) add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, 32'(k));
      else       add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'(k - 2), hd[k - 2], 32'(k));
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  word_addr_t  exp_next;
  word_addr_t  prev_pc;
  logic [31:0] prev_instr;
  logic        prev_stall;
  int          delivered;

  initial begin
    rst = 1'b1; rdy = 1'b1; rv = 1'b0; tgt = '0;

    // Plain run from reset.
    add_rst();
    add_run(7);
    // Stall: decode not ready for cycles 3..7.
    add_rst();
    add_run(3);
    for (int k = 3; k < 8; k++) add(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 32'd1, M1, 32'd3);
    add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'd1, M1, 32'd3);
    add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'd2, M2, 32'd4);
    add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'd3, M3, 32'd5);
    add(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'd4, M4, 32'd6);
    // Redirect to 0 while pc 3 is at the head.
    add_rst();
    add_run(5);
    add(1'b0, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 32'd3, M3, 32'd5);
    add(1'b0, 1'b1, 1'b0, '0,    1'b1, 1'b0, '0,    '0, 32'd0);
    add(1'b0, 1'b1, 1'b0, '0,    1'b1, 1'b0, '0,    '0, 32'd1);
    add(1'b0, 1'b1, 1'b0, '0,    1'b1, 1'b1, 32'd0, M0, 32'd2);
    add(1'b0, 1'b1, 1'b0, '0,    1'b1, 1'b1, 32'd1, M1, 32'd3);
    // Reset together with redirect: reset wins.
    add(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'd2, M2, 32'd4);
    add_run(3);

    @(posedge clk); #1;
    foreach (tv[i]) begin
      rst = tv[i].r; rdy = tv[i].rdy; rv = tv[i].rv; tgt = tv[i].tgt;
      @(negedge clk);
      if (tv[i].chk) begin
        check($sformatf("row%0d valid", i), 32'(bus_a.if_valid), 32'(tv[i].ev));
        check($sformatf("row%0d pc", i),    bus_a.if_pc,          tv[i].epc);
        check($sformatf("row%0d instr", i), bus_a.if_instr,       tv[i].ei);
        check($sformatf("row%0d addr", i),  bus_a.imem_addr,      tv[i].ea);
      end
      @(posedge clk); #1;
    end

    // Address wrap from RESET_PC = FFFFFFFE.
    rst = 1'b1; rdy = 1'b1; rv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      word_addr_t  w_addr [5];
      word_addr_t  w_pc   [5];
      logic [31:0] w_ins  [5];
      logic        w_v    [5];
      w_addr = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
      w_pc   = '{32'h0, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
      w_ins  = '{32'h0, 32'h0, 32'hC3FE_01FE, 32'hC3FF_00FF, M0};
      w_v    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("wrap%0d addr", k),  bus_b.imem_addr,      w_addr[k]);
        check($sformatf("wrap%0d valid", k), 32'(bus_b.if_valid), 32'(w_v[k]));
        check($sformatf("wrap%0d pc", k),    bus_b.if_pc,          w_pc[k]);
        check($sformatf("wrap%0d instr", k), bus_b.if_instr,       w_ins[k]);
        @(posedge clk); #1;
      end
    end

    // Random ready and redirects against a sequential-PC scoreboard.
    rst = 1'b1; rdy = 1'b1; rv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_next = 32'h0; delivered = 0; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
    for (int c = 0; c < 10000; c++) begin
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(40) == 0);
      tgt = $urandom();
      @(negedge clk);
      if (prev_stall) begin
        check("stall valid", 32'(bus_a.if_valid), 32'd1);
        check("stall pc",    bus_a.if_pc,          prev_pc);
        check("stall instr", bus_a.if_instr,       prev_instr);
      end
      if (bus_a.if_valid && rdy) begin
        check("sb pc",    bus_a.if_pc,    exp_next);
        check("sb instr", bus_a.if_instr, mem_word(bus_a.if_pc));
        exp_next = exp_next + 32'd1;
        delivered++;
      end
      prev_stall = bus_a.if_valid && !rdy && !rv;
      prev_pc    = bus_a.if_pc;
      prev_instr = bus_a.if_instr;
      if (rv) exp_next = tgt;
      @(posedge clk); #1;
    end
    check("sb liveness", 32'(delivered > 4000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
